// File: rtl/xgriscv_dbg_pkg.sv
// Shared debug definitions for the xgriscv retirement monitor.
//   mon_state_e       : monitor FSM states
//   DEFAULT_END_PC    : default retire PC that ends a test
//   DEFAULT_TIMEOUT   : default watchdog length in idle cycles
//   trace_entry_t     : one retirement record {pc, instr}
package xgriscv_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } mon_state_e;

  localparam logic [31:0] DEFAULT_END_PC  = 32'h0000_00ff;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } trace_entry_t;

endpackage

// File: rtl/trace_ring.sv
// Circular trace buffer of the last DEPTH retirements.
//   clk, rstn        : clock, synchronous active-low reset
//   wr_en            : store {wr_pc, wr_instr} this cycle
//   rd_idx           : relative read index, 0 = most recent write
//   rd_pc, rd_instr  : entry at rd_idx, zero when rd_idx >= count
//   count            : valid entries, saturating at DEPTH
module trace_ring #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [PC_W-1:0]  wr_pc,
  input  logic [31:0]      wr_instr,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [PC_W-1:0]  rd_pc,
  output logic [31:0]      rd_instr,
  output logic [IDX_W:0]   count
);

  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(DEPTH);

  logic [PC_W-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_addr;
  logic             rd_hit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count != CNT_FULL)
        count <= count + 1'b1;
    end
  end

  // Storage is not reset; stale entries are hidden by count.
  always_ff @(posedge clk) begin
    if (rstn && wr_en) begin
      pc_mem[wr_ptr]    <= wr_pc;
      instr_mem[wr_ptr] <= wr_instr;
    end
  end

  // DEPTH is a power of two, so the subtraction wraps modulo DEPTH.
  always_comb begin
    rd_addr  = wr_ptr - IDX_W'(1) - rd_idx;
    rd_hit   = ({1'b0, rd_idx} < count);
    rd_pc    = rd_hit ? pc_mem[rd_addr]    : '0;
    rd_instr = rd_hit ? instr_mem[rd_addr] : '0;
  end

endmodule

// File: rtl/commit_monitor.sv
// Retirement monitor for the xgriscv cores: counts RUN cycles and retired
// instructions, traces the last TRACE_DEPTH retirements, flags end-of-test
// on END_PC and a watchdog timeout after TIMEOUT consecutive idle cycles.
//   clk, rstn                 : clock, synchronous active-low reset
//   enable_i                  : start monitoring (sampled in IDLE only)
//   retire_valid_i/pc_i/instr_i : writeback-stage retirement
//   trace_idx_i               : trace read index, 0 = most recent
//   trace_pc_o, trace_instr_o : trace entry (combinational)
//   trace_count_o             : valid trace entries
//   cycle_cnt_o, instret_cnt_o: saturating RUN counters
//   running_o, done_o, timeout_o : state flags (done/timeout sticky)
module commit_monitor
  import xgriscv_dbg_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter logic [XLEN-1:0] END_PC  = XLEN'(DEFAULT_END_PC),
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           enable_i,
  input  logic                           retire_valid_i,
  input  logic [XLEN-1:0]                retire_pc_i,
  input  logic [31:0]                    retire_instr_i,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
  output logic [XLEN-1:0]                trace_pc_o,
  output logic [31:0]                    trace_instr_o,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count_o,
  output logic [CNT_W-1:0]               cycle_cnt_o,
  output logic [CNT_W-1:0]               instret_cnt_o,
  output logic                           running_o,
  output logic                           done_o,
  output logic                           timeout_o
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  mon_state_e        state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              in_run;
  logic              trace_wr;

  assign in_run   = (state == ST_RUN);
  assign trace_wr = in_run && retire_valid_i;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      cycle_cnt_o   <= '0;
      instret_cnt_o <= '0;
      idle_cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (in_run) begin
        if (cycle_cnt_o != '1)
          cycle_cnt_o <= cycle_cnt_o + 1'b1;
        if (retire_valid_i) begin
          if (instret_cnt_o != '1)
            instret_cnt_o <= instret_cnt_o + 1'b1;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  // A retirement in the would-be timeout cycle takes priority.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable_i) state_nxt = ST_RUN;
      ST_RUN: begin
        if (retire_valid_i) begin
          if (retire_pc_i == END_PC) state_nxt = ST_DONE;
        end else if (idle_cnt == IDLE_LAST) begin
          state_nxt = ST_TIMEOUT;
        end
      end
      default: state_nxt = state;
    endcase
  end

  assign running_o = (state == ST_RUN);
  assign done_o    = (state == ST_DONE);
  assign timeout_o = (state == ST_TIMEOUT);

  trace_ring #(
    .PC_W  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (trace_wr),
    .wr_pc    (retire_pc_i),
    .wr_instr (retire_instr_i),
    .rd_idx   (trace_idx_i),
    .rd_pc    (trace_pc_o),
    .rd_instr (trace_instr_o),
    .count    (trace_count_o)
  );

endmodule

// File: tb/tb_commit_monitor.sv
module tb_commit_monitor;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 16;
  localparam logic [31:0] ENDPC = 32'h0000_00ff;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable_i;
  logic        retire_valid_i;
  logic [31:0] retire_pc_i;
  logic [31:0] retire_instr_i;
  logic [2:0]  trace_idx_i;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_instr_o;
  logic [3:0]  trace_count_o;
  logic [31:0] cycle_cnt_o;
  logic [31:0] instret_cnt_o;
  logic        running_o, done_o, timeout_o;

  commit_monitor #(
    .XLEN        (32),
    .END_PC      (ENDPC),
    .TRACE_DEPTH (DEPTH),
    .TIMEOUT     (TMO),
    .CNT_W       (32)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .enable_i       (enable_i),
    .retire_valid_i (retire_valid_i),
    .retire_pc_i    (retire_pc_i),
    .retire_instr_i (retire_instr_i),
    .trace_idx_i    (trace_idx_i),
    .trace_pc_o     (trace_pc_o),
    .trace_instr_o  (trace_instr_o),
    .trace_count_o  (trace_count_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .instret_cnt_o  (instret_cnt_o),
    .running_o      (running_o),
    .done_o         (done_o),
    .timeout_o      (timeout_o)
  );

  always #10 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: mode 0 idle, 1 run, 2 done, 3 timeout.
  int          m_mode;
  longint      m_cyc, m_ret;
  int          m_idle_run;
  logic [63:0] m_trace[$];   // front = most recent {pc, instr}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!rstn) begin
      m_mode = 0; m_cyc = 0; m_ret = 0; m_idle_run = 0;
      m_trace.delete();
    end else if (m_mode == 0) begin
      if (enable_i) m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (retire_valid_i) begin
        if (m_ret < 64'hFFFF_FFFF) m_ret++;
        m_trace.push_front({retire_pc_i, retire_instr_i});
        if (m_trace.size() > DEPTH) void'(m_trace.pop_back());
        m_idle_run = 0;
        if (retire_pc_i == ENDPC) m_mode = 2;
      end else begin
        m_idle_run++;
        if (m_idle_run == TMO) m_mode = 3;
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] e;
    check("running", 64'(running_o), 64'(m_mode == 1));
    check("done",    64'(done_o),    64'(m_mode == 2));
    check("timeout", 64'(timeout_o), 64'(m_mode == 3));
    check("cycle_cnt",   64'(cycle_cnt_o),   64'(m_cyc));
    check("instret_cnt", 64'(instret_cnt_o), 64'(m_ret));
    check("trace_count", 64'(trace_count_o), 64'(m_trace.size()));
    for (int i = 0; i < DEPTH; i++) begin
      trace_idx_i = 3'(i);
      #1;
      e = (i < m_trace.size()) ? m_trace[i] : 64'h0;
      check("trace_pc",    64'(trace_pc_o),    64'(e[63:32]));
      check("trace_instr", 64'(trace_instr_o), 64'(e[31:0]));
    end
  endtask

  task automatic tick(input logic rst_n, input logic en, input logic rv, input logic [31:0] pc);
    rstn           = rst_n;
    enable_i       = en;
    retire_valid_i = rv;
    retire_pc_i    = pc;
    retire_instr_i = $urandom;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic read_idx(input logic [2:0] idx);
    trace_idx_i = idx;
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = $urandom & 32'hffff_fffc;
    if (p == ENDPC) p = 32'h100;
    return p;
  endfunction

  initial begin
    int unsigned n, pct;
    logic [31:0] pc;
    rstn = 1'b0; enable_i = 1'b0; retire_valid_i = 1'b0;
    retire_pc_i = '0; retire_instr_i = '0; trace_idx_i = '0;
    m_mode = 0; m_cyc = 0; m_ret = 0; m_idle_run = 0;

    // Reset, then basic run ending on END_PC; retirement during enable ignored.
    tick(0, 0, 0, 0);
    tick(0, 1, 1, 32'h40);
    check("rst_running", 64'(running_o), 64'h0);
    check("rst_count",   64'(trace_count_o), 64'h0);
    tick(1, 1, 1, 32'h100);
    tick(1, 0, 1, 32'h0);
    tick(1, 0, 1, 32'h4);
    tick(1, 0, 1, 32'h8);
    check("pre_done", 64'(done_o), 64'h0);
    tick(1, 0, 1, ENDPC);
    check("t1_done",    64'(done_o), 64'h1);
    check("t1_instret", 64'(instret_cnt_o), 64'd4);
    read_idx(3'd0); check("t1_idx0", 64'(trace_pc_o), 64'hff);
    read_idx(3'd3); check("t1_idx3", 64'(trace_pc_o), 64'h0);

    // Freeze after DONE.
    for (int i = 0; i < 10; i++) tick(1, 1'(i), 1, rand_pc());
    check("frz_instret", 64'(instret_cnt_o), 64'd4);
    check("frz_cycle",   64'(cycle_cnt_o),   64'd4);
    check("frz_done",    64'(done_o),        64'h1);

    // Watchdog after exactly TMO idle RUN cycles.
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    for (int i = 0; i < TMO - 1; i++) tick(1, 0, 0, 0);
    check("wd_early", 64'(timeout_o), 64'h0);
    tick(1, 0, 0, 0);
    check("wd_timeout", 64'(timeout_o), 64'h1);
    check("wd_cycle",   64'(cycle_cnt_o), 64'd16);
    check("wd_done",    64'(done_o), 64'h0);

    // Tie-break: END_PC in the would-be timeout cycle.
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    for (int i = 0; i < TMO - 1; i++) tick(1, 0, 0, 0);
    tick(1, 0, 1, ENDPC);
    check("tie_done",    64'(done_o), 64'h1);
    check("tie_timeout", 64'(timeout_o), 64'h0);

    // Tie-break: ordinary retirement restarts the watchdog.
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    for (int i = 0; i < TMO - 1; i++) tick(1, 0, 0, 0);
    tick(1, 0, 1, 32'h40);
    for (int i = 0; i < TMO - 1; i++) tick(1, 0, 0, 0);
    check("tie2_running", 64'(running_o), 64'h1);
    tick(1, 0, 0, 0);
    check("tie2_timeout", 64'(timeout_o), 64'h1);

    // Wrap-around with 11 retirements.
    tick(0, 0, 0, 0);
    read_idx(3'd5); check("wrap_empty", 64'(trace_pc_o), 64'h0);
    tick(1, 1, 0, 0);
    for (int i = 0; i < 11; i++) tick(1, 0, 1, 32'(4 * i));
    check("wrap_count", 64'(trace_count_o), 64'd8);
    read_idx(3'd0); check("wrap_idx0", 64'(trace_pc_o), 64'h28);
    read_idx(3'd7); check("wrap_idx7", 64'(trace_pc_o), 64'h0c);

    // Reset mid-run, then a fresh run.
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 0, 1, rand_pc());
    tick(0, 1, 1, rand_pc());
    check("mid_instret", 64'(instret_cnt_o), 64'h0);
    check("mid_cycle",   64'(cycle_cnt_o),   64'h0);
    check("mid_running", 64'(running_o),     64'h0);
    check("mid_count",   64'(trace_count_o), 64'h0);
    tick(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 1, rand_pc());
    check("mid_rerun", 64'(instret_cnt_o), 64'd3);

    // Randomized runs with varying retire density.
    for (int r = 0; r < 30; r++) begin
      tick(0, 0, 0, 0);
      tick(1, 1, 1'($urandom), rand_pc());
      n   = $urandom_range(20, 80);
      pct = (r % 5 == 0) ? 0 : $urandom_range(5, 100);
      for (int k = 0; k < n; k++) begin
        pc = ($urandom_range(0, 99) < 2) ? ENDPC : rand_pc();
        tick(1, 1'($urandom), 1'($urandom_range(0, 99) < pct), pc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
